// File: rtl/seg_reg_elastic.sv
// Elastic pipeline segment register: valid/ready payload stage with optional
// 2-entry skid buffer, hazard flush and a saturating downstream-bubble counter.
module seg_reg_elastic #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned CTRL_W  = 8,
    parameter int unsigned SKID    = 1,
    parameter int unsigned COUNT_W = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_in_valid,
    output logic               o_in_ready,
    input  logic [DATA_W-1:0]  i_in_data,
    input  logic [CTRL_W-1:0]  i_in_ctrl,
    input  logic               i_flush,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [DATA_W-1:0]  o_out_data,
    output logic [CTRL_W-1:0]  o_out_ctrl,
    output logic [1:0]         o_occupancy,
    output logic [COUNT_W-1:0] o_bubble_count
);

    localparam bit USE_SKID = (SKID != 0);

    logic               r_main_v;
    logic               r_skid_v;
    logic               r_in_ready;
    logic [DATA_W-1:0]  r_main_data;
    logic [CTRL_W-1:0]  r_main_ctrl;
    logic [DATA_W-1:0]  r_skid_data;
    logic [CTRL_W-1:0]  r_skid_ctrl;
    logic [COUNT_W-1:0] r_bubble_count;

    logic               w_main_v_n;
    logic               w_skid_v_n;
    logic [DATA_W-1:0]  w_main_data_n;
    logic [CTRL_W-1:0]  w_main_ctrl_n;
    logic [DATA_W-1:0]  w_skid_data_n;
    logic [CTRL_W-1:0]  w_skid_ctrl_n;
    logic [COUNT_W-1:0] w_bubble_n;
    logic               w_xfer_in;
    logic               w_xfer_out;
    logic               w_accept;

    // Without the skid buffer, ready must see downstream ready in the same cycle.
    assign o_in_ready  = USE_SKID ? r_in_ready : (!r_main_v || i_out_ready);
    assign w_xfer_in   = i_in_valid && o_in_ready;
    assign w_xfer_out  = r_main_v && i_out_ready;
    // A flush kills the incoming entry even when the handshake completes.
    assign w_accept    = w_xfer_in && !i_flush;

    assign o_out_valid = r_main_v;
    assign o_out_data  = r_main_data;
    assign o_out_ctrl  = r_main_v ? r_main_ctrl : '0;
    assign o_occupancy = {1'b0, r_main_v} + {1'b0, r_skid_v};
    assign o_bubble_count = r_bubble_count;

    // Next-state for the main/skid entries.
    always_comb begin
        w_main_v_n    = r_main_v;
        w_skid_v_n    = r_skid_v;
        w_main_data_n = r_main_data;
        w_main_ctrl_n = r_main_ctrl;
        w_skid_data_n = r_skid_data;
        w_skid_ctrl_n = r_skid_ctrl;
        if (i_flush) begin
            w_main_v_n = 1'b0;
            w_skid_v_n = 1'b0;
        end else if (!USE_SKID) begin
            if (w_accept) begin
                w_main_v_n    = 1'b1;
                w_main_data_n = i_in_data;
                w_main_ctrl_n = i_in_ctrl;
            end else if (w_xfer_out) begin
                w_main_v_n = 1'b0;
            end
        end else if (!r_main_v) begin
            if (w_accept) begin
                w_main_v_n    = 1'b1;
                w_main_data_n = i_in_data;
                w_main_ctrl_n = i_in_ctrl;
            end
        end else if (w_xfer_out) begin
            if (r_skid_v) begin
                w_skid_v_n    = 1'b0;
                w_main_data_n = r_skid_data;
                w_main_ctrl_n = r_skid_ctrl;
            end else if (w_accept) begin
                w_main_data_n = i_in_data;
                w_main_ctrl_n = i_in_ctrl;
            end else begin
                w_main_v_n = 1'b0;
            end
        end else if (w_accept) begin
            w_skid_v_n    = 1'b1;
            w_skid_data_n = i_in_data;
            w_skid_ctrl_n = i_in_ctrl;
        end
    end

    // Saturating count of cycles where downstream waited on an empty stage.
    always_comb begin
        w_bubble_n = r_bubble_count;
        if (i_out_ready && !r_main_v && (r_bubble_count != '1)) begin
            w_bubble_n = r_bubble_count + COUNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_main_v       <= 1'b0;
            r_skid_v       <= 1'b0;
            r_in_ready     <= 1'b1;
            r_main_data    <= '0;
            r_main_ctrl    <= '0;
            r_skid_data    <= '0;
            r_skid_ctrl    <= '0;
            r_bubble_count <= '0;
        end else begin
            r_main_v       <= w_main_v_n;
            r_skid_v       <= w_skid_v_n;
            r_in_ready     <= !w_skid_v_n;
            r_main_data    <= w_main_data_n;
            r_main_ctrl    <= w_main_ctrl_n;
            r_skid_data    <= w_skid_data_n;
            r_skid_ctrl    <= w_skid_ctrl_n;
            r_bubble_count <= w_bubble_n;
        end
    end

endmodule

// File: doc/seg_reg_elastic.md
Name: seg_reg_elastic

Overview:
Parametrised elastic pipeline segment register for the MIPS pipeline. It replaces fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block.
- Carries a generic data payload plus a control payload over a valid/ready handshake.
- Has an optional 2-entry skid buffer, a hazard-unit flush and a bubble counter.
- Control bits are forced to zero whenever no valid instruction is presented, so an empty stage is always a NOP downstream.

Parameters:
DATA_W, 32, width of datapath payload (operands, offsets, register indices packed by the instantiating stage)
CTRL_W, 8, width of control payload (reg_dst, alu_src, alu_op, mem_read/write, mem_to_reg, reg_write, ...); zeroed on bubble/flush
SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready
COUNT_W, 16, width of bubble counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  upstream stage presents an instruction
in_ready  output  1  block can accept this cycle
in_data  input  DATA_W  upstream datapath payload
in_ctrl  input  CTRL_W  upstream control payload
flush  input  1  synchronous kill of all held and incoming entries (branch taken / hazard)
out_valid  output  1  entry presented downstream
out_ready  input  1  downstream accepts
out_data  output  DATA_W  head-entry datapath payload
out_ctrl  output  CTRL_W  head-entry control payload; all zero when out_valid=0
occupancy  output  2  number of held entries (0..2; max 1 when SKID=0)
bubble_count  output  COUNT_W  cycles where downstream was ready but out_valid=0; saturating

Behaviour:
- Reset (async, asserts immediately):
  - main_v=0, skid_v=0; all data/ctrl registers 0.
  - out_valid=0, out_ctrl=0, out_data=0, occupancy=0, bubble_count=0.
  - in_ready=1 when SKID=1 (registered reg, reset value 1). When SKID=0, in_ready follows its combinational formula (=1).
  - Reset asserted mid-transfer discards every held entry; no partial state survives.
- Handshake: transfer in = in_valid & in_ready; transfer out = out_valid & out_ready. in_valid need not wait for in_ready.
- out_valid=main_v; out_data=main_data; out_ctrl=main_v ? main_ctrl : 0.
- SKID=0:
  - in_ready = !main_v | out_ready.
  - Main loads on transfer-in; main_v clears on transfer-out without transfer-in.
  - Latency 1 cycle; full throughput.
- SKID=1 (all register updates on the clock edge):
  - main empty, transfer-in: main<=in, main_v=1.
  - main full, transfer-out, skid empty, transfer-in: main<=in.
  - main full, transfer-out, skid empty, no transfer-in: main_v=0.
  - main full, no transfer-out, transfer-in: skid<=in, skid_v=1.
  - transfer-out with skid full: main<=skid, skid_v=0 (in_ready was 0, so no transfer-in that cycle).
  - in_ready register next value = !skid_v_next. in_ready never depends combinationally on out_ready.
  - Latency 1 cycle; full throughput with out_ready held high.
- Ordering: strict FIFO; entries are never reordered or duplicated.
- Flush (synchronous, highest priority below reset):
  - Next edge: main_v=0, skid_v=0, in_ready=1 (SKID=1).
  - Any entry presented on in_* in the flush cycle is discarded, even if in_ready=1.
  - A transfer-out in the flush cycle still completes (downstream sampled it).
  - Data registers are not cleared; ctrl output reads 0 via the valid gating.
- occupancy = main_v + skid_v.
- bubble_count: +1 on each edge where out_ready=1 and out_valid=0 (reset cycles excluded). Saturates at all-ones; never wraps. Flush cycles count normally.

Test Plan:
- Reset then stream 10 entries (in_data=k, in_ctrl=8'hA5) with out_ready=1 -> out_valid from cycle 1, out_data 0..9 one per cycle, bubble_count=1 (first idle cycle).
- SKID=1, main full (data 7), out_ready=0, push 8 -> occupancy=2, in_ready=0 next cycle; raise out_ready -> 7 then 8 delivered in order, in_ready=1 after first pop.
- Flush with occupancy=2 and in_valid=1 (data 9) -> next cycle out_valid=0, out_ctrl=0, occupancy=0; data 9 never appears.
- SKID=0, out_ready toggling 1010..., continuous input -> in_ready mirrors formula, no entry lost or duplicated (scoreboard).
- COUNT_W=4, out_ready=1, in_valid=0 for 20 cycles -> bubble_count stops at 15.
- Assert reset asynchronously mid-cycle with occupancy=2 -> outputs zero immediately, before next clk edge.
